// File: rtl/mem_responder.sv
// Line-refill / line-writeback memory responder: 4-word lines, critical-word-first
// reads with programmable first-beat latency and inter-beat gap, single-cycle writes.
module mem_responder #(
  parameter int WORD_WIDTH = 32,
  parameter int ADR_WIDTH  = 32,
  parameter int MEM_AW     = 10,
  parameter int FIRST_LAT  = 4,
  parameter int BEAT_GAP   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_cc2mem,
  input  logic [ADR_WIDTH-1:0]    adr_cc2mem,
  output logic                    ack_mem2cc,
  output logic [WORD_WIDTH-1:0]   dat_mem2cc,
  input  logic                    wreq_cc2mem,
  input  logic [ADR_WIDTH-1:0]    wadr_cc2mem,
  input  logic [4*WORD_WIDTH-1:0] wdat_cc2mem,
  output logic                    wack_mem2cc,
  output logic                    busy,
  output logic                    err_overlap
);

  localparam int          DEPTH    = 2 ** MEM_AW;
  localparam logic [3:0]  LAT_LOAD = 4'(FIRST_LAT - 1);
  localparam logic [1:0]  GAP_LOAD = 2'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);

  typedef enum logic [2:0] {IDLE, WRITE, LATENCY, BEAT, GAP} state_t;

  state_t                  state, state_d;
  logic [3:0]              lat_cnt, lat_d;
  logic [1:0]              gap_cnt, gap_d;
  logic [1:0]              beat_cnt, beat_d;
  logic [MEM_AW-1:0]       rd_word, rd_word_d;
  logic [MEM_AW-3:0]       wr_line_adr, wr_line_adr_d;
  logic [4*WORD_WIDTH-1:0] wr_line, wr_line_d;
  logic                    pend, pend_d;
  logic                    ack_q, ack_d;
  logic [WORD_WIDTH-1:0]   dat_q, dat_d;
  logic                    wack_q, wack_d;
  logic                    err_q, err_d;
  logic                    fire;
  logic                    mem_we;
  logic [MEM_AW-1:0]       rd_idx;

  // Storage is zero at power-up but deliberately untouched by rst.
  logic [WORD_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Byte offsets and aliased upper address bits carry no meaning here.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{adr_cc2mem, wadr_cc2mem};

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d       = state;
    lat_d         = lat_cnt;
    gap_d         = gap_cnt;
    beat_d        = beat_cnt;
    rd_word_d     = rd_word;
    wr_line_adr_d = wr_line_adr;
    wr_line_d     = wr_line;
    pend_d        = pend;
    wack_d        = 1'b0;
    fire          = 1'b0;
    mem_we        = 1'b0;
    err_d         = err_q | ((state != IDLE) & (req_cc2mem | wreq_cc2mem));

    unique case (state)
      IDLE: begin
        if (wreq_cc2mem) begin
          wr_line_adr_d = wadr_cc2mem[MEM_AW+1:4];
          wr_line_d     = wdat_cc2mem;
          state_d       = WRITE;
          if (req_cc2mem) begin
            pend_d    = 1'b1;
            rd_word_d = adr_cc2mem[MEM_AW+1:2];
          end
        end else if (req_cc2mem) begin
          rd_word_d = adr_cc2mem[MEM_AW+1:2];
          lat_d     = LAT_LOAD;
          state_d   = LATENCY;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        wack_d = 1'b1;
        pend_d = 1'b0;
        if (pend) begin
          lat_d   = LAT_LOAD;
          state_d = LATENCY;
        end else begin
          state_d = IDLE;
        end
      end
      LATENCY: begin
        if (lat_cnt == 4'd0) begin
          beat_d  = 2'd0;
          fire    = 1'b1;
          state_d = BEAT;
        end else begin
          lat_d = lat_cnt - 4'd1;
        end
      end
      BEAT: begin
        if (beat_cnt == 2'd3) begin
          state_d = IDLE;
        end else if (BEAT_GAP == 0) begin
          beat_d = beat_cnt + 2'd1;
          fire   = 1'b1;
        end else begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 2'd0) begin
          beat_d  = beat_cnt + 2'd1;
          fire    = 1'b1;
          state_d = BEAT;
        end else begin
          gap_d = gap_cnt - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Critical word first: the beat index wraps inside the 4-word line.
    rd_idx = {rd_word[MEM_AW-1:2], 2'(rd_word[1:0] + beat_d)};
    ack_d  = fire;
    dat_d  = fire ? mem[rd_idx] : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      gap_cnt     <= '0;
      beat_cnt    <= '0;
      rd_word     <= '0;
      wr_line_adr <= '0;
      wr_line     <= '0;
      pend        <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      wack_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_d;
      lat_cnt     <= lat_d;
      gap_cnt     <= gap_d;
      beat_cnt    <= beat_d;
      rd_word     <= rd_word_d;
      wr_line_adr <= wr_line_adr_d;
      wr_line     <= wr_line_d;
      pend        <= pend_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      wack_q      <= wack_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the storage array has no reset branch; clearing it would force a flop-based memory.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        mem[{wr_line_adr, 2'(i)}] <= wr_line[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign ack_mem2cc  = ack_q;
  assign dat_mem2cc  = dat_q;
  assign wack_mem2cc = wack_q;
  assign busy        = (state != IDLE);
  assign err_overlap = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters (name, default, meaning): WORD_WIDTH, 32, data word width in bits.
REQ-002 ADR_WIDTH, 32, byte address width.
REQ-003 MEM_AW, 10, log2 of backing-store depth in words.
REQ-004 FIRST_LAT, 4, cycles from read-request capture to first beat; legal range 1..15.
REQ-005 BEAT_GAP, 0, idle cycles inserted between consecutive read beats; legal range 0..3.
REQ-006 Line size is fixed at 4 words (128 bits); it is not parameterised.
REQ-007 Ports (name, direction, width, meaning): clk, in, 1, clock; all logic on the rising edge.
REQ-008 rst, in, 1, synchronous, active-high reset.
REQ-009 req_cc2mem, in, 1, single-cycle line-refill request pulse.
REQ-010 adr_cc2mem, in, ADR_WIDTH, refill byte address; valid with req_cc2mem.
REQ-011 ack_mem2cc, out, 1, one-cycle pulse per returned word.
REQ-012 dat_mem2cc, out, WORD_WIDTH, returned word; valid only while ack_mem2cc is high.
REQ-013 wreq_cc2mem, in, 1, single-cycle line-writeback request pulse.
REQ-014 wadr_cc2mem, in, ADR_WIDTH, writeback byte address; valid with wreq_cc2mem.
REQ-015 wdat_cc2mem, in, 4*WORD_WIDTH, writeback line; word i in bits [32i+31:32i].
REQ-016 wack_mem2cc, out, 1, one-cycle pulse on writeback completion.
REQ-017 busy, out, 1, high in every state other than IDLE.
REQ-018 err_overlap, out, 1, sticky flag set when a request is dropped.

Function
REQ-019 Storage is a WORD_WIDTH x 2^MEM_AW array, indexed by word address adr[MEM_AW+1:2].
- Byte offset adr[1:0] is ignored.
- Address bits above MEM_AW+1 are ignored (aliasing).
REQ-020 Line base = word address with bits [1:0] cleared; critical word offset = adr[3:2].
REQ-021 Read beat k (k = 0..3) returns word base | ((offset + k) mod 4), i.e. critical-word-first with wrap-around.
REQ-022 FSM states: IDLE, WRITE, LATENCY, BEAT, GAP.
REQ-023 IDLE transitions:
- wreq sampled: capture address and line, go to WRITE.
- only req sampled: capture address, go to LATENCY with latency counter loaded.
REQ-024 If req and wreq are sampled in the same cycle, the write is served first.
- The read is held in a pending register and enters LATENCY right after WRITE.
REQ-025 WRITE lasts exactly one cycle: all 4 words are written, and wack_mem2cc pulses in that cycle.
REQ-026 The first ack_mem2cc is high in the cycle that begins FIRST_LAT rising edges after the edge that sampled req.
REQ-027 In BEAT, ack_mem2cc is high for one cycle; the beat counter increments (2-bit, wraps).
- After beat 3, return to IDLE.
- Otherwise go to GAP for BEAT_GAP cycles, or straight to the next BEAT when BEAT_GAP = 0.
REQ-028 With BEAT_GAP = 0, the 4 acks occupy 4 consecutive cycles.
REQ-029 A new request may be sampled in the cycle after the last ack or wack (back-to-back operation).
REQ-030 Read data reflects any write completed on an earlier cycle.
- A writeback followed by a refill of the same line returns the new data.
REQ-031 req or wreq sampled while busy is dropped, except the pending read of REQ-024.
- A dropped request sets err_overlap; an in-flight transfer is unaffected.
REQ-032 dat_mem2cc = 0 whenever ack_mem2cc = 0.
REQ-033 ack_mem2cc, dat_mem2cc and wack_mem2cc are registered outputs; no input-to-output combinational path.

Reset
REQ-034 While rst is high at a clock edge: state goes to IDLE; counters and pending register clear; all outputs go to 0, including err_overlap.
REQ-035 Reset mid-transfer aborts the transfer; no further ack or wack is issued.
- A write is either complete or not started; a partial write is not possible because WRITE is a single cycle.
REQ-036 Storage contents are not cleared by rst; they are zero at time zero.
REQ-037 Requests asserted in the same cycle as rst are ignored.

Verification
REQ-038 Read: FIRST_LAT=4, BEAT_GAP=0, mem[0x40..0x43] = A0..A3, req with adr 0x108 at cycle 0.
- Acks in cycles 4, 5, 6, 7.
- Data A2, A3, A0, A1.
- busy low at cycle 8.
REQ-039 Write then read, same cycle: req and wreq both at adr 0x200, wdat = {D3,D2,D1,D0}.
- wack at cycle 1.
- Acks in cycles 1+FIRST_LAT .. 4+FIRST_LAT with data D0..D3.
REQ-040 Gap: BEAT_GAP=2, req at adr 0x0.
- Acks spaced 3 cycles apart, 4 acks total.
- dat_mem2cc = 0 between acks.
REQ-041 Overlap: second req issued 2 cycles after the first.
- err_overlap = 1.
- Only the first line is returned, with 4 acks.
REQ-042 Reset mid-transfer: rst high after the 2nd ack.
- No further acks; all outputs 0.
- A new req 1 cycle after rst returns the full line correctly.
REQ-043 Alias: adr 0x1000_0104 with MEM_AW=10 reads the same word as 0x104.
